uart_core: RTL and testbench
============================

UART_CORE -- requirements
Module: uart_core

Interface
REQ-001 Parameter DATA_W, default 8, meaning serial data bits per frame; legal range 5..9.
REQ-002 Parameter DIV_W, default 16, meaning width of the baud divisor.
REQ-003 Clk  input  1  system clock; all state on posedge Clk.
REQ-004 Rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 BaudDiv  input  DIV_W  16x-oversample tick divisor; tick period = BaudDiv+1 Clk cycles.
REQ-006 ParityEn  input  1  1 = parity bit present after data.
REQ-007 ParityOdd  input  1  1 = odd parity, 0 = even; ignored when ParityEn=0.
REQ-008 TwoStop  input  1  1 = two stop bits transmitted, 0 = one.
REQ-009 Loopback  input  1  1 = receiver fed from internal transmit line.
REQ-010 TxData  input  DATA_W  word to send.
REQ-011 TxValid  input  1  TxData valid.
REQ-012 TxReady  output  1  transmitter can accept a word.
REQ-013 Tx  output  1  serial out, idle high.
REQ-014 Rx  input  1  serial in, asynchronous to Clk.
REQ-015 RxData  output  DATA_W  last received word.
REQ-016 RxValid  output  1  RxData holds unconsumed word.
REQ-017 RxReady  input  1  consumer accepts RxData.
REQ-018 RxParityErr, RxFrameErr, RxOverrun  output  1 each  status of the word in RxData.

Function
REQ-019 Tick generator: free-running counter; one-cycle tick when counter = BaudDiv, then counter clears; BaudDiv=0 gives tick every cycle; BaudDiv change takes effect at next wrap.
REQ-020 Bit period = 16 ticks for every start, data, parity and stop bit.
REQ-021 TX FSM states IDLE, START, DATA, PARITY, STOP; TxReady=1 only in IDLE.
REQ-022 Transfer accepted on the cycle TxValid && TxReady; TxData, ParityEn, ParityOdd, TwoStop captured then; FSM enters START; Tx goes low the following cycle.
REQ-023 Data shifted LSB first, DATA_W bits; PARITY state skipped when ParityEn=0; parity bit = XOR of data bits, inverted when ParityOdd=1.
REQ-024 STOP drives Tx=1 for 16 or 32 ticks; then IDLE, TxReady=1 the next cycle; back-to-back words carry no extra idle gap.
REQ-025 Rx passed through a 2-flop synchroniser; receive source is Tx-internal when Loopback=1, else synchronised Rx.
REQ-026 While Loopback=1 the Tx pin is held 1; external Rx ignored. Loopback captured only while both FSMs are IDLE.
REQ-027 RX FSM states IDLE, START, DATA, PARITY, STOP; IDLE->START on source low.
REQ-028 START: sample at tick 8; if source high, false start, return IDLE with no output change; else continue, sampling each later bit at its mid-point (16 ticks apart).
REQ-029 Parity checked when ParityEn=1; only the first stop bit is sampled; stop=0 sets frame error.
REQ-030 Frame completion after stop sample: RxData, RxParityErr, RxFrameErr loaded, RxValid=1 in the same cycle; RX returns IDLE and may detect a new start immediately.
REQ-031 If RxValid=1 and not consumed in the completion cycle, the new word overwrites RxData and RxOverrun=1; otherwise RxOverrun=0.
REQ-032 RxValid clears the cycle after RxValid && RxReady unless a completion occurs in that same cycle (completion wins, RxOverrun=0).
REQ-033 TX and RX operate independently and concurrently (full duplex).

Reset
REQ-034 Rst_n low asynchronously forces: Tx=1, TxReady=1, RxValid=0, RxData=0, all error flags 0, both FSMs IDLE, tick counter 0, synchroniser flops 1.
REQ-035 Reset mid-frame abandons the frame; no partial word is ever presented after release.

Verification
REQ-036 BaudDiv=0, 8N1, Loopback=1, send 0xA5 -> RxData=0xA5, RxValid set ~160 Clk after accept, no error flags, Tx pin stays 1.
REQ-037 BaudDiv=3, ParityEn=1, ParityOdd=1, send 0x03 -> Tx shows parity bit 1; RX loopback RxParityErr=0; inject flipped parity on Rx -> RxParityErr=1.
REQ-038 External Rx frame 0x3C with stop bit driven 0 -> RxData=0x3C, RxFrameErr=1.
REQ-039 RxReady=0, two loopback words 0x11 then 0x22 -> RxData=0x22, RxOverrun=1, RxValid=1.
REQ-040 Rx low pulse of 4 ticks -> false start, RxValid stays 0; Rst_n low mid-TX of 0xFF -> Tx=1, TxReady=1 immediately.
REQ-041 DATA_W=5 and TwoStop=1, send 0x15 -> Tx frame is 1 start, 5 data, 2 stop bits (128 ticks), RxData=0x15.

Source files
------------

// File: rtl/uart_core.sv
// Full-duplex UART core with 16x oversampling, optional parity, one or two stop
// bits and an internal loopback path from the transmitter to the receiver.
module uart_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIV_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [DIV_W-1:0]  BaudDiv,
  input  logic              ParityEn,
  input  logic              ParityOdd,
  input  logic              TwoStop,
  input  logic              Loopback,
  input  logic [DATA_W-1:0] TxData,
  input  logic              TxValid,
  output logic              TxReady,
  output logic              Tx,
  input  logic              Rx,
  output logic [DATA_W-1:0] RxData,
  output logic              RxValid,
  input  logic              RxReady,
  output logic              RxParityErr,
  output logic              RxFrameErr,
  output logic              RxOverrun
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uartState_e;

  localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

  // Tick generator; the divisor is latched at each wrap so a new BaudDiv
  // never strands the counter above the compare value.
  logic [DIV_W-1:0] divCnt;
  logic [DIV_W-1:0] divLat;
  logic             tick;

  assign tick = (divCnt == divLat);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      divCnt <= '0;
      divLat <= '0;
    end else if (tick) begin
      divCnt <= '0;
      divLat <= BaudDiv;
    end else begin
      divCnt <= divCnt + 1'b1;
    end
  end

  // Transmitter
  uartState_e        txState, txStateNext;
  logic [3:0]        txTick, txTickNext;
  logic [3:0]        txBit, txBitNext;
  logic [DATA_W-1:0] txShift, txShiftNext;
  logic              txParBit, txParBitNext;
  logic              txParEn, txParEnNext;
  logic              txTwoStop, txTwoStopNext;
  logic              txStop2, txStop2Next;
  logic              txLine, txLineNext;
  logic              txBitEnd;

  assign txBitEnd = (txState != IDLE) && tick && (txTick == 4'hF);

  always_comb begin
    txStateNext   = txState;
    txTickNext    = txTick;
    txBitNext     = txBit;
    txShiftNext   = txShift;
    txParBitNext  = txParBit;
    txParEnNext   = txParEn;
    txTwoStopNext = txTwoStop;
    txStop2Next   = txStop2;
    txLineNext    = 1'b1;

    if (txState != IDLE && tick) txTickNext = txTick + 1'b1;

    case (txState)
      IDLE: begin
        if (TxValid) begin
          txStateNext   = START;
          txShiftNext   = TxData;
          txParBitNext  = (^TxData) ^ ParityOdd;
          txParEnNext   = ParityEn;
          txTwoStopNext = TwoStop;
          txTickNext    = '0;
          txBitNext     = '0;
          txStop2Next   = 1'b0;
        end
      end
      START: begin
        if (txBitEnd) txStateNext = DATA;
      end
      DATA: begin
        if (txBitEnd) begin
          txShiftNext = txShift >> 1;
          if (txBit == LAST_BIT) begin
            txStateNext = txParEn ? PARITY : STOP;
          end else begin
            txBitNext = txBit + 1'b1;
          end
        end
      end
      PARITY: begin
        if (txBitEnd) txStateNext = STOP;
      end
      STOP: begin
        if (txBitEnd) begin
          if (txTwoStop && !txStop2) txStop2Next = 1'b1;
          else                       txStateNext = IDLE;
        end
      end
      default: txStateNext = IDLE;
    endcase

    // Line level is registered from the next state so Tx is glitch-free.
    case (txStateNext)
      START:   txLineNext = 1'b0;
      DATA:    txLineNext = txShiftNext[0];
      PARITY:  txLineNext = txParBitNext;
      default: txLineNext = 1'b1;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      txState   <= IDLE;
      txTick    <= '0;
      txBit     <= '0;
      txShift   <= '0;
      txParBit  <= 1'b0;
      txParEn   <= 1'b0;
      txTwoStop <= 1'b0;
      txStop2   <= 1'b0;
      txLine    <= 1'b1;
    end else begin
      txState   <= txStateNext;
      txTick    <= txTickNext;
      txBit     <= txBitNext;
      txShift   <= txShiftNext;
      txParBit  <= txParBitNext;
      txParEn   <= txParEnNext;
      txTwoStop <= txTwoStopNext;
      txStop2   <= txStop2Next;
      txLine    <= txLineNext;
    end
  end

  // Receive source selection and loopback mode
  uartState_e rxState, rxStateNext;
  logic       lbReg;
  logic       rxMeta, rxSync;
  logic       rxSrc;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      lbReg  <= 1'b0;
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
    end else begin
      rxMeta <= Rx;
      rxSync <= rxMeta;
      if (txState == IDLE && rxState == IDLE) lbReg <= Loopback;
    end
  end

  assign rxSrc   = lbReg ? txLine : rxSync;
  assign Tx      = lbReg | txLine;
  assign TxReady = (txState == IDLE);

  // Receiver
  logic [3:0]        rxTick, rxTickNext;
  logic [3:0]        rxBit, rxBitNext;
  logic [DATA_W-1:0] rxShift, rxShiftNext;
  logic              rxParEn, rxParEnNext;
  logic              rxParOdd, rxParOddNext;
  logic              rxParErrAcc, rxParErrAccNext;
  logic              rxSample;
  logic              rxDone;

  // Start bit is checked at its mid-point (8th tick); later bits every 16.
  assign rxSample = tick && (rxState != IDLE) &&
                    ((rxState == START) ? (rxTick == 4'd7) : (rxTick == 4'hF));

  always_comb begin
    rxStateNext     = rxState;
    rxTickNext      = rxTick;
    rxBitNext       = rxBit;
    rxShiftNext     = rxShift;
    rxParEnNext     = rxParEn;
    rxParOddNext    = rxParOdd;
    rxParErrAccNext = rxParErrAcc;
    rxDone          = 1'b0;

    if (rxState != IDLE && tick) rxTickNext = rxTick + 1'b1;

    case (rxState)
      IDLE: begin
        if (!rxSrc) begin
          rxStateNext     = START;
          rxTickNext      = '0;
          rxBitNext       = '0;
          rxParEnNext     = ParityEn;
          rxParOddNext    = ParityOdd;
          rxParErrAccNext = 1'b0;
        end
      end
      START: begin
        if (rxSample) begin
          rxTickNext  = '0;
          rxStateNext = rxSrc ? IDLE : DATA;
        end
      end
      DATA: begin
        if (rxSample) begin
          rxShiftNext = {rxSrc, rxShift[DATA_W-1:1]};
          if (rxBit == LAST_BIT) begin
            rxStateNext = rxParEn ? PARITY : STOP;
          end else begin
            rxBitNext = rxBit + 1'b1;
          end
        end
      end
      PARITY: begin
        if (rxSample) begin
          rxParErrAccNext = rxSrc ^ (^rxShift) ^ rxParOdd;
          rxStateNext     = STOP;
        end
      end
      STOP: begin
        if (rxSample) begin
          rxDone      = 1'b1;
          rxStateNext = IDLE;
        end
      end
      default: rxStateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rxState     <= IDLE;
      rxTick      <= '0;
      rxBit       <= '0;
      rxShift     <= '0;
      rxParEn     <= 1'b0;
      rxParOdd    <= 1'b0;
      rxParErrAcc <= 1'b0;
    end else begin
      rxState     <= rxStateNext;
      rxTick      <= rxTickNext;
      rxBit       <= rxBitNext;
      rxShift     <= rxShiftNext;
      rxParEn     <= rxParEnNext;
      rxParOdd    <= rxParOddNext;
      rxParErrAcc <= rxParErrAccNext;
    end
  end

  // Completion takes priority over a same-cycle consume.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      RxData      <= '0;
      RxValid     <= 1'b0;
      RxParityErr <= 1'b0;
      RxFrameErr  <= 1'b0;
      RxOverrun   <= 1'b0;
    end else if (rxDone) begin
      RxData      <= rxShift;
      RxParityErr <= rxParErrAcc;
      RxFrameErr  <= ~rxSrc;
      RxValid     <= 1'b1;
      RxOverrun   <= RxValid & ~RxReady;
    end else if (RxValid && RxReady) begin
      RxValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: loopback, parity, framing, overrun, false start,
// mid-frame reset and a 5-bit two-stop-bit instance.
module tb_uart_core;

  logic        clk = 1'b0;
  logic        rstN;
  logic [15:0] baudDiv;
  logic        parityEn, parityOdd, twoStop, loopback;
  logic [7:0]  txData;
  logic        txValid, txReady, txPin;
  logic        rxPin, rxDrv, extLoop;
  logic [7:0]  rxData;
  logic        rxValid, rxReady, rxParErr, rxFrameErr, rxOverrun;

  logic [15:0] baud5;
  logic [4:0]  txData5, rxData5;
  logic        txValid5, txReady5, txPin5;
  logic        rxValid5, rxParErr5, rxFrameErr5, rxOverrun5;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign rxPin = extLoop ? txPin : rxDrv;

  uart_core #(.DATA_W(8), .DIV_W(16)) dut (
    .Clk(clk), .Rst_n(rstN), .BaudDiv(baudDiv), .ParityEn(parityEn),
    .ParityOdd(parityOdd), .TwoStop(twoStop), .Loopback(loopback),
    .TxData(txData), .TxValid(txValid), .TxReady(txReady), .Tx(txPin),
    .Rx(rxPin), .RxData(rxData), .RxValid(rxValid), .RxReady(rxReady),
    .RxParityErr(rxParErr), .RxFrameErr(rxFrameErr), .RxOverrun(rxOverrun)
  );

  uart_core #(.DATA_W(5), .DIV_W(16)) dut5 (
    .Clk(clk), .Rst_n(rstN), .BaudDiv(baud5), .ParityEn(1'b0),
    .ParityOdd(1'b0), .TwoStop(1'b1), .Loopback(1'b0),
    .TxData(txData5), .TxValid(txValid5), .TxReady(txReady5), .Tx(txPin5),
    .Rx(txPin5), .RxData(rxData5), .RxValid(rxValid5), .RxReady(1'b0),
    .RxParityErr(rxParErr5), .RxFrameErr(rxFrameErr5), .RxOverrun(rxOverrun5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns just after the accepting edge.
  task automatic sendTx(input logic [7:0] d);
    int budget;
    budget = 0;
    @(negedge clk);
    txData  = d;
    txValid = 1'b1;
    while (!txReady && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 3000) check("tx_accept_timeout", 0, 1);
    @(posedge clk);
    #1 txValid = 1'b0;
  endtask

  task automatic waitRxValid(input string tag, input int budget);
    int n;
    n = 0;
    while (!rxValid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, rxValid, 1);
  endtask

  task automatic consume();
    @(negedge clk);
    rxReady = 1'b1;
    @(negedge clk);
    rxReady = 1'b0;
  endtask

  // Samples the Tx pin at bit mid-points after the start edge.
  task automatic captureTx(input int nbits, input int period, output logic [31:0] val);
    int n;
    n   = 0;
    val = '0;
    while (txPin !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("tx_start_timeout", 0, 1);
    cycles(period / 2);
    val[0] = txPin;
    for (int k = 1; k < nbits; k++) begin
      cycles(period);
      val[k] = txPin;
    end
  endtask

  // Stop bit held for 3/4 of a period so a 0 stop cannot look like a new start.
  task automatic sendRx(input logic [7:0] d, input bit usePar, input bit par,
                        input bit stopBit, input int period);
    @(negedge clk);
    rxDrv = 1'b0;
    cycles(period);
    for (int i = 0; i < 8; i++) begin
      rxDrv = d[i];
      cycles(period);
    end
    if (usePar) begin
      rxDrv = par;
      cycles(period);
    end
    rxDrv = stopBit;
    cycles(period * 3 / 4);
    rxDrv = 1'b1;
    cycles(period);
  endtask

  initial begin
    logic [31:0] frame;
    int          lat;
    bit          txDropped;
    int          n5;
    logic [7:0]  bits5;

    rstN = 1'b0; baudDiv = '0; parityEn = 0; parityOdd = 0; twoStop = 0;
    loopback = 0; txData = '0; txValid = 0; rxDrv = 1; extLoop = 0; rxReady = 0;
    baud5 = '0; txData5 = '0; txValid5 = 0;
    cycles(3);
    check("rst_tx", txPin, 1);
    check("rst_txready", txReady, 1);
    check("rst_rxvalid", rxValid, 0);
    check("rst_rxdata", rxData, 0);
    check("rst_flags", {rxParErr, rxFrameErr, rxOverrun}, 0);
    check("rst_tx5", txPin5, 1);
    rstN = 1'b1;
    cycles(3);

    // 8N1 loopback at one tick per clock
    loopback = 1;
    cycles(3);
    sendTx(8'hA5);
    lat = 0;
    txDropped = 0;
    while (lat < 400) begin
      @(negedge clk);
      if (txPin !== 1'b1) txDropped = 1;
      if (rxValid) break;
      lat++;
    end
    check("lb_latency_ok", (lat >= 150 && lat <= 165), 1);
    check("lb_data", rxData, 8'hA5);
    check("lb_flags", {rxParErr, rxFrameErr, rxOverrun}, 0);
    check("lb_txpin_high", txDropped, 0);
    consume();
    check("consume_clears", rxValid, 0);

    // Odd parity on the pin, looped back externally
    cycles(200);
    loopback = 0; extLoop = 1; baudDiv = 16'd3; parityEn = 1; parityOdd = 1;
    cycles(10);
    sendTx(8'h03);
    captureTx(11, 64, frame);
    check("par_txframe", frame[10:0], 11'h606);
    waitRxValid("par_rx_wait", 300);
    check("par_rx_data", rxData, 8'h03);
    check("par_rx_perr", rxParErr, 0);
    consume();
    cycles(100);

    // Flipped parity injected on Rx
    extLoop = 0;
    sendRx(8'h03, 1, 0, 1, 64);
    waitRxValid("perr_wait", 300);
    check("perr_data", rxData, 8'h03);
    check("perr_flag", rxParErr, 1);
    check("perr_ferr", rxFrameErr, 0);
    consume();

    // Frame error: stop bit driven low
    parityEn = 0; parityOdd = 0;
    sendRx(8'h3C, 0, 0, 0, 64);
    waitRxValid("ferr_wait", 300);
    check("ferr_data", rxData, 8'h3C);
    check("ferr_flag", rxFrameErr, 1);
    check("ferr_perr", rxParErr, 0);
    consume();
    cycles(100);

    // Overrun: two looped-back words, nothing consumed
    baudDiv = '0; loopback = 1;
    cycles(10);
    sendTx(8'h11);
    sendTx(8'h22);
    cycles(200);
    check("ovr_data", rxData, 8'h22);
    check("ovr_flag", rxOverrun, 1);
    check("ovr_valid", rxValid, 1);
    consume();
    check("ovr_consumed", rxValid, 0);
    cycles(50);

    // False start: Rx low for 4 ticks
    loopback = 0; baudDiv = 16'd3;
    cycles(10);
    @(negedge clk);
    rxDrv = 0;
    cycles(16);
    rxDrv = 1;
    cycles(300);
    check("false_start", rxValid, 0);

    // Reset in the middle of a transmitted 0xFF
    extLoop = 1;
    sendTx(8'hFF);
    cycles(100);
    #2 rstN = 1'b0;
    #1;
    check("midrst_tx", txPin, 1);
    check("midrst_txready", txReady, 1);
    check("midrst_rxvalid", rxValid, 0);
    cycles(3);
    rstN = 1'b1;
    cycles(800);
    check("midrst_no_partial", rxValid, 0);
    extLoop = 0;

    // DATA_W=5, two stop bits, external loop on the 5-bit instance
    @(negedge clk);
    txData5  = 5'h15;
    txValid5 = 1'b1;
    n5 = 0;
    while (!txReady5 && n5 < 1000) begin
      @(negedge clk);
      n5++;
    end
    @(posedge clk);
    #1 txValid5 = 1'b0;
    n5 = 0;
    bits5 = '0;
    while (n5 < 300) begin
      @(negedge clk);
      if (txReady5) break;
      if ((n5 % 16) == 8) bits5[n5 / 16] = txPin5;
      n5++;
    end
    check("w5_frame_cycles", n5, 128);
    check("w5_frame_bits", bits5, 8'hEA);
    n5 = 0;
    while (!rxValid5 && n5 < 300) begin
      @(negedge clk);
      n5++;
    end
    check("w5_rx_valid", rxValid5, 1);
    check("w5_rx_data", rxData5, 5'h15);
    check("w5_rx_flags", {rxParErr5, rxFrameErr5, rxOverrun5}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
